controlador_detector_sequencia: RTL

Controller that sequences a serial pattern-detection run. On a start request it latches a 4-bit pattern, a hit target and a timeout, then arms an internal pattern-detector datapath. It counts detections on the serial input `x` and finishes when the target is reached, the timeout expires or (optionally) an abort arrives. It sits between the control logic that issues detection jobs and the serial input line, reporting the result through a start/busy/done handshake.

---
 rtl/controlador_detector_sequencia_pkg.sv | 27 ++
 rtl/controlador_detector_sequencia_if.sv | 42 ++++
 rtl/controlador_detector_sequencia_detector_padrao.sv | 42 ++++
 rtl/controlador_detector_sequencia.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/controlador_detector_sequencia_pkg.sv
// Shared definitions for the serial pattern-detection controller: default widths,
// FSM state encoding and a small state-decoding helper.
package controlador_detector_sequencia_pkg;

  localparam int PATTERN_W = 4;
  localparam int CNT_W     = 8;
  localparam int TIMEOUT_W = 12;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A job is in flight from the arming cycle until the done pulse has been shown.
  function automatic logic state_busy(input state_t s);
    return s != ST_IDLE;
  endfunction

  // The abort path is only allowed to cut a job short before its result exists.
  function automatic logic state_abortable(input state_t s);
    return (s == ST_ARM) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/controlador_detector_sequencia_if.sv
// Job handshake between the issuing control logic and the detection controller.
// Optional abort/aborted signals exist only when CONTROLADOR_DETECTOR_ABORT_EN is defined.
interface controlador_detector_sequencia_if #(
  parameter int PATTERN_W = controlador_detector_sequencia_pkg::PATTERN_W,
  parameter int CNT_W     = controlador_detector_sequencia_pkg::CNT_W,
  parameter int TIMEOUT_W = controlador_detector_sequencia_pkg::TIMEOUT_W
);

  logic                 start;
  logic [PATTERN_W-1:0] pattern;
  logic [CNT_W-1:0]     target;
  logic [TIMEOUT_W-1:0] timeout;
  logic                 busy;
  logic                 done;
  logic                 timed_out;
  logic [CNT_W-1:0]     hits;
`ifdef CONTROLADOR_DETECTOR_ABORT_EN
  logic                 abort;
  logic                 aborted;
`endif

  // Issuer side: requests jobs and watches the result.
  modport master (
    output start, pattern, target, timeout,
`ifdef CONTROLADOR_DETECTOR_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  busy, done, timed_out, hits
  );

  // Controller side.
  modport slave (
    input  start, pattern, target, timeout,
`ifdef CONTROLADOR_DETECTOR_ABORT_EN
    input  abort,
    output aborted,
`endif
    output busy, done, timed_out, hits
  );

endinterface

// File: rtl/controlador_detector_sequencia_detector_padrao.sv
// Serial pattern matcher: shifts one bit per enabled cycle and reports a match once
// at least PATTERN_W bits have been collected since the last clear.
module detector_padrao #(
  parameter int PATTERN_W = controlador_detector_sequencia_pkg::PATTERN_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 x,
  input  logic [PATTERN_W-1:0] pattern,
  output logic                 match
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  // Oldest sample sits in the MSB so the history reads like the pattern literal.
  logic [PATTERN_W-1:0] history;
  logic [FILL_W-1:0]    fill;

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values, independent of the order the always blocks are evaluated in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      history <= '0;
      fill    <= '0;
    end else if (clear) begin
      history <= '0;
      fill    <= '0;
    end else if (enable) begin
      history <= {history[PATTERN_W-2:0], x};
      if (fill != FILL_FULL) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // A cleared history of zeros must not match pattern 0000 before it has filled.
  assign match = (fill == FILL_FULL) && (history == pattern);

endmodule

// File: rtl/controlador_detector_sequencia.sv
// Job controller for serial pattern detection: latches a job on start, counts matches
// until target/timeout (or abort with CONTROLADOR_DETECTOR_ABORT_EN) and reports done.
module controlador_detector_sequencia #(
  parameter int PATTERN_W = controlador_detector_sequencia_pkg::PATTERN_W,
  parameter int CNT_W     = controlador_detector_sequencia_pkg::CNT_W,
  parameter int TIMEOUT_W = controlador_detector_sequencia_pkg::TIMEOUT_W
) (
  input  logic                            clock,
  input  logic                            reset,
  controlador_detector_sequencia_if.slave bus,
  input  logic                            x,
  output logic                            y
);

  import controlador_detector_sequencia_pkg::*;

  state_t               state;

  // Job configuration captured on the accepting start edge.
  logic [PATTERN_W-1:0] cfg_pattern;
  logic [CNT_W-1:0]     cfg_target;
  logic [TIMEOUT_W-1:0] cfg_timeout;

  logic [CNT_W-1:0]     hits_q;
  logic [TIMEOUT_W-1:0] cycle_cnt;
  logic                 timed_out_q;

  logic                 accept;
  logic                 in_run;
  logic                 match;
  logic [CNT_W-1:0]     hits_inc;
  logic                 target_hit;
  logic                 timeout_hit;
  logic                 abort_req;

  assign accept = (state == ST_IDLE) && bus.start;
  assign in_run = (state == ST_RUN);

  detector_padrao #(
    .PATTERN_W (PATTERN_W)
  ) u_detector (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .enable  (in_run),
    .x       (x),
    .pattern (cfg_pattern),
    .match   (match)
  );

  // NOTE: every signal written here is assigned on every path through the block,
  // so no latch is inferred.
  always_comb begin
    hits_inc    = (&hits_q) ? hits_q : hits_q + CNT_W'(1);
    target_hit  = match && (hits_inc == cfg_target);
    timeout_hit = (cfg_timeout != '0) && (cycle_cnt == cfg_timeout - TIMEOUT_W'(1));
  end

`ifdef CONTROLADOR_DETECTOR_ABORT_EN
  logic aborted_q;

  assign abort_req = bus.abort && state_abortable(state);

  // Result flag: survives DONE and IDLE, cleared only by the next accepted job.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aborted_q <= 1'b0;
    end else if (accept) begin
      aborted_q <= 1'b0;
    end else if (abort_req) begin
      aborted_q <= 1'b1;
    end
  end

  assign bus.aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      cfg_pattern <= '0;
      cfg_target  <= '0;
      cfg_timeout <= '0;
      hits_q      <= '0;
      cycle_cnt   <= '0;
      timed_out_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state       <= ST_ARM;
            cfg_pattern <= bus.pattern;
            cfg_target  <= bus.target;
            cfg_timeout <= bus.timeout;
            hits_q      <= '0;
            cycle_cnt   <= '0;
            timed_out_q <= 1'b0;
          end
        end

        ST_ARM: begin
          // A zero target is met before any sample is taken.
          if (abort_req || (cfg_target == '0)) begin
            state <= ST_DONE;
          end else begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (abort_req) begin
            // Abort wins over a match on the same edge; hits keeps its old value.
            state <= ST_DONE;
          end else begin
            cycle_cnt <= cycle_cnt + TIMEOUT_W'(1);
            if (match) begin
              hits_q <= hits_inc;
            end
            // Reaching the target on the timeout edge still reports success.
            if (target_hit) begin
              state <= ST_DONE;
            end else if (timeout_hit) begin
              state       <= ST_DONE;
              timed_out_q <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = state_busy(state);
  assign bus.done      = (state == ST_DONE);
  assign bus.timed_out = timed_out_q;
  assign bus.hits      = hits_q;
  assign y             = in_run && match;

endmodule
